// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, picks the 16-bit instruction word out of a
// 32-bit cache line and registers it together with the following constant word.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic [31:0] fetch_opc,
    input  logic        hold,
    input  logic        pc_w,
    input  logic [15:0] pc_alu,
    input  logic        pc_inc,
    input  logic        pc_inv,
    output logic [15:0] pc_out,
    output logic [15:0] ir_out,
    output logic [15:0] k16_out,
    output logic        ir_valid
);

    localparam logic [15:0] RESET_PC_EVEN = RESET_PC & 16'hFFFE;

    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] k16;
    logic        valid;

    logic [15:0] sel_word;
    logic [15:0] const_word;
    logic [15:0] pc_next;
    logic        valid_next;

    // The constant word only exists for even-aligned instructions; an odd
    // instruction sits in the low half and its successor lives in the next line.
    always_comb begin
        sel_word   = fetch_opc[31:16];
        const_word = fetch_opc[15:0];
        if (pc[1]) begin
            sel_word   = fetch_opc[15:0];
            const_word = 16'h0000;
        end
    end

    // A branch load overrides a stall so a taken branch is never lost.
    always_comb begin
        pc_next = pc;
        if (pc_w)
            pc_next = pc_alu & 16'hFFFE;
        else if (!hold && pc_inc)
            pc_next = pc + 16'd2;
    end

    // The line captured alongside a branch belongs to the old PC, so it is dropped.
    always_comb begin
        valid_next = 1'b1;
        if (pc_inv || pc_w)
            valid_next = 1'b0;
        else if (hold)
            valid_next = valid;
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            pc    <= RESET_PC_EVEN;
            ir    <= 16'h0000;
            k16   <= 16'h0000;
            valid <= 1'b0;
        end else begin
            pc    <= pc_next;
            valid <= valid_next;
            if (!hold) begin
                ir  <= sel_word;
                k16 <= const_word;
            end
        end
    end

    assign pc_out   = pc;
    assign ir_out   = ir;
    assign k16_out  = k16;
    assign ir_valid = valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a cache model where word n holds the value n
// and the line at pc[15:2] is {word 2k, word 2k+1}.
module tb_fetch_unit;

    logic        clk;
    logic        a_rst;
    logic [31:0] fetch_opc;
    logic        hold;
    logic        pc_w;
    logic [15:0] pc_alu;
    logic        pc_inc;
    logic        pc_inv;
    logic [15:0] pc_out;
    logic [15:0] ir_out;
    logic [15:0] k16_out;
    logic        ir_valid;

    int checks;
    int failures;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .fetch_opc (fetch_opc),
        .hold      (hold),
        .pc_w      (pc_w),
        .pc_alu    (pc_alu),
        .pc_inc    (pc_inc),
        .pc_inv    (pc_inv),
        .pc_out    (pc_out),
        .ir_out    (ir_out),
        .k16_out   (k16_out),
        .ir_valid  (ir_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cacheLine(input logic [15:0] addr);
        logic [15:0] even_word;
        even_word = {1'b0, addr[15:2], 1'b0};
        return {even_word, even_word | 16'h0001};
    endfunction

    // The cache presents the line for the current PC on the falling edge.
    always @(negedge clk) fetch_opc = cacheLine(pc_out);

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [15:0] exp_pc, input logic [15:0] exp_ir,
                              input logic [15:0] exp_k16, input logic exp_valid);
        checkOutput({tag, ".pc"}, pc_out, exp_pc);
        checkOutput({tag, ".ir"}, ir_out, exp_ir);
        checkOutput({tag, ".k16"}, k16_out, exp_k16);
        checkOutput({tag, ".valid"}, {15'd0, ir_valid}, {15'd0, exp_valid});
    endtask

    task automatic applyStimulus(input logic h, input logic w, input logic [15:0] alu,
                                 input logic inc, input logic inv);
        hold   = h;
        pc_w   = w;
        pc_alu = alu;
        pc_inc = inc;
        pc_inv = inv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        a_rst     = 1'b0;
        fetch_opc = 32'h0;
        hold      = 1'b0;
        pc_w      = 1'b0;
        pc_alu    = 16'h0;
        pc_inc    = 1'b0;
        pc_inv    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkState("reset_init", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        a_rst = 1'b1;

        // Sequential fetch from 0
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkState("seq1", 16'h0002, 16'h0000, 16'h0001, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkState("seq2", 16'h0004, 16'h0001, 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkState("seq3", 16'h0006, 16'h0002, 16'h0003, 1'b1);

        // Asynchronous reset mid-run, away from any clock edge
        #2;
        a_rst = 1'b0;
        #1;
        checkState("reset_async", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        a_rst = 1'b1;

        // Invalidate while advancing
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        checkState("inv1", 16'h0002, 16'h0000, 16'h0001, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        checkState("inv2", 16'h0004, 16'h0001, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkState("inv_end", 16'h0006, 16'h0002, 16'h0003, 1'b1);

        // Branch to odd target address, bit 0 dropped
        applyStimulus(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0);
        checkState("branch", 16'h0010, 16'h0003, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkState("branch_next", 16'h0012, 16'h0008, 16'h0009, 1'b1);

        // Stall freezes everything, but a branch still loads the PC
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            checkState("hold", 16'h0012, 16'h0008, 16'h0009, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
        checkState("hold_branch", 16'h0040, 16'h0008, 16'h0009, 1'b0);

        // Branch wins over increment, then wrap past the top of memory
        applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        checkState("wrap_load", 16'hFFFE, 16'h0020, 16'h0021, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkState("wrap", 16'h0000, 16'h7FFF, 16'h0000, 1'b1);

        // Idle: same word re-captured and valid
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkState("idle1", 16'h0000, 16'h0000, 16'h0001, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkState("idle2", 16'h0000, 16'h0000, 16'h0001, 1'b1);

        // Invalidate during a stall still clears valid
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        checkState("hold_inv", 16'h0000, 16'h0000, 16'h0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name:
fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit CPU.
- Owns the program counter (byte address, 16-bit instructions, always even).
- Each cycle it takes a 32-bit aligned line from the instruction cache (two 16-bit words), selects the instruction word at PC, and registers it as the IR together with the following constant word (k16).
- Supports stall (hold), branch load (pc_w), sequential increment (pc_inc) and pipeline invalidation (pc_inv).

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 is ignored and forced to 0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- a_rst  input  1  asynchronous active-low reset.
- fetch_opc  input  32  cache line addressed by pc_out[15:2]. [31:16] is the even word (pc[1]=0); [15:0] is the odd word (pc[1]=1). Must be stable before each rising edge; the cache updates it on the falling edge from pc_out.
- hold  input  1  stall: freeze PC, IR, k16 and ir_valid.
- pc_w  input  1  load PC from pc_alu (branch/jump).
- pc_alu  input  16  branch target byte address.
- pc_inc  input  1  advance PC by one instruction (+2).
- pc_inv  input  1  mark the instruction captured this cycle as invalid (flush).
- pc_out  output  16  current PC register; bit 0 always 0.
- ir_out  output  16  registered instruction word.
- k16_out  output  16  registered constant word following the instruction.
- ir_valid  output  1  ir_out/k16_out hold a valid instruction.

Behaviour:
- Reset (a_rst=0, asynchronous, any time, including mid-operation): pc_out=RESET_PC with bit0=0; ir_out=0; k16_out=0; ir_valid=0. Reset takes priority over everything. Release is sampled at the next rising edge.
- Word select (combinational): sel = pc_out[1] ? fetch_opc[15:0] : fetch_opc[31:16]. const = pc_out[1] ? 16'h0000 : fetch_opc[15:0]. The constant is only available for even-aligned instructions; odd alignment yields 0.
- PC update per rising edge, priority order:
  1. pc_w=1: pc <= {pc_alu[15:1],1'b0}. This applies even when hold=1.
  2. Otherwise, hold=1: pc unchanged.
  3. Otherwise, pc_inc=1: pc <= pc+2, modulo 2^16 (0xFFFE wraps to 0x0000).
  4. Otherwise: pc unchanged.
- IR/k16 update per rising edge:
  - hold=0: ir_out <= sel, k16_out <= const.
  - hold=1: both retain their values.
- ir_valid update per rising edge:
  - pc_inv=1: ir_valid <= 0, regardless of hold.
  - Else pc_w=1: ir_valid <= 0, because the line fetched belongs to the old PC.
  - Else hold=1: ir_valid unchanged.
  - Else: ir_valid <= 1.
- Latency:
  - The instruction at PC value P appears on ir_out one edge after P is on pc_out.
  - After pc_w, the first valid instruction appears on the second edge.
- If neither pc_w nor pc_inc is asserted and hold=0, the same word is re-captured each cycle, and it is valid if pc_inv=0.
- pc_inc together with pc_w: pc_w wins.
- No combinational path from inputs to outputs; all outputs are registers.

Test Plan:
The cache model uses word n = 0x00nn, with the line at pc[15:2] = {word 2k, word 2k+1}.

1. Reset: assert a_rst=0 mid-run with pc=0x0006 and ir_valid=1 -> immediately pc_out=0x0000, ir_out=0, k16_out=0, ir_valid=0 without waiting for a clock edge.
2. Sequential fetch: after reset with pc_inc=1, pc_inv=0, hold=0:
   - edge 1: ir=0x0000, k16=0x0001, valid=1, pc=0x0002.
   - edge 2: ir=0x0001, k16=0x0000, pc=0x0004.
   - edge 3: ir=0x0002, k16=0x0003, pc=0x0006.
3. Invalidate: pc_inv=1 with pc_inc=1 for 2 edges -> pc advances by 4, ir_out updates, ir_valid=0. After pc_inv drops, ir_valid=1 on the next edge.
4. Branch: pc_w=1, pc_alu=0x0011 -> pc=0x0010 and valid=0 on that edge. Next edge with pc_inc=1: ir=0x0008, k16=0x0009, valid=1, pc=0x0012.
5. Hold: hold=1 for 3 edges with pc_inc=1 -> pc, ir, k16 and ir_valid unchanged. With hold=1 and pc_w=1, pc_alu=0x0040 -> pc=0x0040 and ir_valid=0.
6. Wrap: pc_w with pc_alu=0xFFFE, then pc_inc=1 -> pc goes 0xFFFE then 0x0000. ir = odd word of the line at 0xFFFC, k16=0x0000.
